// File: rtl/core_run_pkg.sv
// ---------------------------------------------------------------------------
// core_run_pkg
//   Shared definitions for the core run controller: the sequencer state
//   encoding and the default parameter values used by core_run_ctrl and
//   its cycle counter.
// ---------------------------------------------------------------------------
package core_run_pkg;

  // Sequencer phases. The explicit encoding is kept stable so the legacy
  // localparam state constants in the controller map onto it one-to-one.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } run_state_t;

  // Default configuration.
  localparam int DEF_AW       = 8;
  localparam int DEF_LD_BASE  = 0;
  localparam int DEF_LD_MAX   = 256;
  localparam int DEF_RES_BASE = 64;
  localparam int DEF_RES_LEN  = 16;
  localparam int DEF_CW       = 16;
  localparam int DEF_MAX_CYC  = 4096;

endpackage

// File: rtl/run_cycle_ctr.sv
// ---------------------------------------------------------------------------
// run_cycle_ctr
//   Saturating CW-bit cycle counter with synchronous clear and count enable.
//   It also provides the watchdog compare. o_limitHit fires in the enabled
//   cycle whose increment brings the count to LIMIT. LIMIT = 0 disables the
//   compare entirely.
//
// Ports
//   i_clk       in   1    clock
//   i_rst_n     in   1    asynchronous active-low reset
//   i_clear     in   1    synchronous clear (wins over enable)
//   i_en        in   1    count this cycle
//   o_count     out  CW   current count, holds at all-ones
//   o_limitHit  out  1    this enabled cycle takes the count to LIMIT
// ---------------------------------------------------------------------------
module run_cycle_ctr
  import core_run_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int LIMIT = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_limitHit
);

  logic [CW-1:0] r_count;
  logic          w_sat;

  assign w_sat   = &r_count;
  assign o_count = r_count;

  // The counter stops at all-ones instead of wrapping, so a long run
  // never reports a misleadingly small cycle count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !w_sat) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The hit is raised while the count is still LIMIT-1. The controller can
  // then leave RUN on the same edge that records the final count.
  generate
    if (LIMIT > 0) begin : g_watch
      assign o_limitHit = i_en && (r_count == CW'(LIMIT - 1));
    end else begin : g_noWatch
      assign o_limitHit = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/core_run_ctrl.sv
// ---------------------------------------------------------------------------
// core_run_ctrl
//   Host-side sequencer around the 8-bit processor core.
//   IDLE  -> waits for start
//   LOAD  -> writes an incoming byte stream into data memory (core held in reset)
//   RUN   -> releases the core, counts cycles until core_done
//   DRAIN -> streams RES_LEN result bytes back out of data memory
//   The data-memory port belongs to this block (mem_sel=1) except during
//   RUN, when the core owns it. The data-memory port mux is selected by
//   mem_sel outside this block.
//
// Configuration macro
//   CORE_RUN_TIMEOUT_EN : enables the RUN watchdog. If RUN lasts MAX_CYC
//                         counted cycles without core_done, the block moves
//                         to DRAIN and raises the sticky timeout flag.
//                         Without the macro, timeout is tied low.
//
// Ports
//   clk          in   1   clock
//   reset        in   1   asynchronous, active-low reset
//   start        in   1   begin LOAD (only honoured in IDLE)
//   ld_valid     in   1   load byte valid
//   ld_ready     out  1   load byte accepted when ld_valid & ld_ready
//   ld_data      in   8   load byte
//   ld_last      in   1   final load byte
//   mem_sel      out  1   1 = this block drives data memory, 0 = core
//   mem_wr_en    out  1   data-memory write strobe
//   mem_addr     out  AW  data-memory address
//   mem_wr_data  out  8   data-memory write data
//   mem_rd_data  in   8   data-memory combinational read data
//   core_reset   out  1   active-high core reset
//   core_done    in   1   core finished
//   rd_valid     out  1   result byte valid
//   rd_ready     in   1   result sink ready
//   rd_data      out  8   result byte
//   rd_last      out  1   final result byte
//   busy         out  1   not IDLE
//   cycle_count  out  CW  core cycles in last/current RUN
//   timeout      out  1   sticky watchdog flag
// ---------------------------------------------------------------------------
module core_run_ctrl
  import core_run_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int LD_BASE  = DEF_LD_BASE,
  parameter int LD_MAX   = DEF_LD_MAX,
  parameter int RES_BASE = DEF_RES_BASE,
  parameter int RES_LEN  = DEF_RES_LEN,
  parameter int CW       = DEF_CW,
  parameter int MAX_CYC  = DEF_MAX_CYC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [7:0]    rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [CW-1:0] cycle_count,
  output logic          timeout
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_LOAD  = LOAD;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

`ifdef CORE_RUN_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif
  localparam int WD_LIMIT = WD_EN ? MAX_CYC : 0;

  logic [1:0]    r_state;
  logic [AW-1:0] r_ptr;
  logic          r_firstRun;

  logic          w_start;
  logic          w_ldAccept;
  logic          w_ldEnd;
  logic          w_rdFire;
  logic          w_rdLast;
  logic          w_cntEn;
  logic          w_doneSeen;
  logic          w_limitHit;
  logic [CW-1:0] w_cycleCount;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_ldAccept = (r_state == ST_LOAD) && ld_valid;
  // The LD_MAX cap ends LOAD on the byte that fills it. Any further bytes
  // then see ld_ready=0 and are never written.
  assign w_ldEnd    = w_ldAccept && (ld_last || (r_ptr == AW'(LD_MAX - 1)));
  assign w_rdLast   = (r_ptr == AW'(RES_LEN - 1));
  assign w_rdFire   = (r_state == ST_DRAIN) && rd_ready;
  // The first RUN cycle still holds the core in reset. It is neither
  // counted nor allowed to see core_done.
  assign w_cntEn    = (r_state == ST_RUN) && !r_firstRun;
  assign w_doneSeen = w_cntEn && core_done;

  run_cycle_ctr #(
    .CW    (CW),
    .LIMIT (WD_LIMIT)
  ) u_cycleCtr (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_clear    (w_start),
    .i_en       (w_cntEn),
    .o_count    (w_cycleCount),
    .o_limitHit (w_limitHit)
  );

  assign cycle_count = w_cycleCount;

  // Sequencer state, the shared LOAD/DRAIN byte pointer and the
  // first-RUN-cycle marker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_firstRun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_ptr   <= '0;
          end
        end
        ST_LOAD: begin
          if (w_ldEnd) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_firstRun <= 1'b1;
          end else if (w_ldAccept) begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        ST_RUN: begin
          r_firstRun <= 1'b0;
          if (w_doneSeen || w_limitHit) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_rdFire) begin
            if (w_rdLast) begin
              r_state <= ST_IDLE;
              r_ptr   <= '0;
            end else begin
              r_ptr <= r_ptr + AW'(1);
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CORE_RUN_TIMEOUT_EN
  logic r_timeout;

  // The watchdog flag stays set until the next accepted start. A genuine
  // done in the limit cycle takes priority and does not count as a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
    end else if (w_start) begin
      r_timeout <= 1'b0;
    end else if (w_limitHit && !core_done) begin
      r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  // Host-side memory and stream outputs decoded from the current state.
  // Outside RUN the core stays in reset and this block owns memory.
  always_comb begin
    ld_ready   = 1'b0;
    mem_sel    = 1'b1;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    rd_valid   = 1'b0;
    rd_last    = 1'b0;
    core_reset = 1'b1;
    case (r_state)
      ST_LOAD: begin
        ld_ready  = 1'b1;
        mem_wr_en = ld_valid;
        mem_addr  = AW'(LD_BASE) + r_ptr;
      end
      ST_RUN: begin
        mem_sel    = 1'b0;
        core_reset = r_firstRun;
      end
      ST_DRAIN: begin
        mem_addr = AW'(RES_BASE) + r_ptr;
        rd_valid = 1'b1;
        rd_last  = w_rdLast;
      end
      default: begin
      end
    endcase
  end

  assign mem_wr_data = ld_data;
  assign rd_data     = mem_rd_data;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. It models the data memory, including
//   the core-side write path used while mem_sel=0. It also keeps scoreboard
//   queues for the expected memory writes and the expected result bytes.
// ---------------------------------------------------------------------------
module tb_core_run_ctrl;

  localparam int AW       = 8;
  localparam int LD_BASE  = 0;
  localparam int LD_MAX   = 4;
  localparam int RES_BASE = 64;
  localparam int RES_LEN  = 2;
  localparam int CW       = 16;
  localparam int MAX_CYC  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          ldValid = 1'b0;
  logic          ldReady;
  logic [7:0]    ldData = 8'h00;
  logic          ldLast = 1'b0;
  logic          memSel;
  logic          memWrEn;
  logic [AW-1:0] memAddr;
  logic [7:0]    memWrData;
  logic [7:0]    memRdData;
  logic          coreReset;
  logic          coreDone = 1'b0;
  logic          rdValid;
  logic          rdReady = 1'b0;
  logic [7:0]    rdData;
  logic          rdLast;
  logic          busy;
  logic [CW-1:0] cycleCount;
  logic          timeout;

  logic [7:0]    mem [256];
  logic          coreWe = 1'b0;
  logic [7:0]    coreAddr = 8'h00;
  logic [7:0]    coreData = 8'h00;

  int            assertCount = 0;
  int            failCount = 0;
  logic [15:0]   wrQ [$];
  logic [8:0]    rdQ [$];

  core_run_ctrl #(
    .AW(AW), .LD_BASE(LD_BASE), .LD_MAX(LD_MAX), .RES_BASE(RES_BASE),
    .RES_LEN(RES_LEN), .CW(CW), .MAX_CYC(MAX_CYC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ldValid), .ld_ready(ldReady), .ld_data(ldData), .ld_last(ldLast),
    .mem_sel(memSel), .mem_wr_en(memWrEn), .mem_addr(memAddr),
    .mem_wr_data(memWrData), .mem_rd_data(memRdData),
    .core_reset(coreReset), .core_done(coreDone),
    .rd_valid(rdValid), .rd_ready(rdReady), .rd_data(rdData), .rd_last(rdLast),
    .busy(busy), .cycle_count(cycleCount), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Data memory, with the port mux steered by mem_sel.
  assign memRdData = mem[memAddr];
  always @(posedge clk) begin
    if (memSel && memWrEn) mem[memAddr] <= memWrData;
    else if (!memSel && coreWe) mem[coreAddr] <= coreData;
  end

  task automatic applyStimulus(input logic st, input logic lv, input logic [7:0] ld,
                               input logic ll, input logic rr, input logic cd);
    start    = st;
    ldValid  = lv;
    ldData   = ld;
    ldLast   = ll;
    rdReady  = rr;
    coreDone = cd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  loadBytes [3];
    logic [15:0] expWr;
    logic [8:0]  expRd;
    int          n;
    loadBytes = '{8'h11, 8'h22, 8'h33};

    // Reset values
    #3;
    checkOutput("rstCoreReset", 32'(coreReset), 32'd1);
    checkOutput("rstMemSel", 32'(memSel), 32'd1);
    checkOutput("rstLdReady", 32'(ldReady), 32'd0);
    checkOutput("rstRdValid", 32'(rdValid), 32'd0);
    checkOutput("rstMemWrEn", 32'(memWrEn), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstCycleCount", 32'(cycleCount), 32'd0);
    checkOutput("rstTimeout", 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();

    // Start, then a 3-byte load ending with ld_last
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, loadBytes[i], (i == 2), 1'b0, 1'b0);
      wrQ.push_back({8'(LD_BASE + i), loadBytes[i]});
      @(negedge clk);
      checkOutput("loadReady", 32'(ldReady), 32'd1);
      checkOutput("loadWrEn", 32'(memWrEn), 32'd1);
      expWr = (wrQ.size() > 0) ? wrQ.pop_front() : 16'hxxxx;
      checkOutput("loadWrite", 32'({memAddr, memWrData}), 32'(expWr));
      nextCycle();
    end

    // First RUN cycle: the core is still in reset, so done is ignored
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("run0MemSel", 32'(memSel), 32'd0);
    checkOutput("run0CoreReset", 32'(coreReset), 32'd1);
    checkOutput("run0LdReady", 32'(ldReady), 32'd0);
    checkOutput("memByte1", 32'(mem[1]), 32'h22);
    nextCycle();

    // Core runs; done in the 10th cycle after the reset falls
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, (k == 10));
      coreWe   = (k <= 2);
      coreAddr = 8'(RES_BASE + k - 1);
      coreData = (k == 1) ? 8'hA5 : 8'h5A;
      @(negedge clk);
      if (k == 1) checkOutput("runCoreReset", 32'(coreReset), 32'd0);
      if (k == 1) checkOutput("runIgnoredDone", 32'(memSel), 32'd0);
      if (k == 5) checkOutput("runMidCount", 32'(cycleCount), 32'd4);
      nextCycle();
    end
    coreWe = 1'b0;

    // Drain with rd_ready toggling 0/1
    rdQ.push_back({1'b0, 8'hA5});
    rdQ.push_back({1'b1, 8'h5A});
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, (j % 2 == 1), 1'b0);
      @(negedge clk);
      if (j == 0) begin
        checkOutput("doneCount", 32'(cycleCount), 32'd10);
        checkOutput("drainCoreReset", 32'(coreReset), 32'd1);
        checkOutput("drainMemSel", 32'(memSel), 32'd1);
      end
      checkOutput("drainValid", 32'(rdValid), 32'd1);
      checkOutput("drainAddr", 32'(memAddr), 32'(RES_BASE + j / 2));
      if (rdReady) begin
        expRd = (rdQ.size() > 0) ? rdQ.pop_front() : 9'hxxx;
        checkOutput("drainByte", 32'({rdLast, rdData}), 32'(expRd));
      end else begin
        expRd = (rdQ.size() > 0) ? rdQ[0] : 9'hxxx;
        checkOutput("drainHold", 32'({rdLast, rdData}), 32'(expRd));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("postDrainBusy", 32'(busy), 32'd0);
    checkOutput("postDrainRdValid", 32'(rdValid), 32'd0);
    checkOutput("countHeld", 32'(cycleCount), 32'd10);
    checkOutput("rdQueueEmpty", 32'(rdQ.size()), 32'd0);
    nextCycle();

    // Overflow load: 6 bytes offered without last, only LD_MAX accepted
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      if (i < LD_MAX) wrQ.push_back({8'(LD_BASE + i), 8'(8'h40 + i)});
      @(negedge clk);
      if (i == 0) checkOutput("startClearsCount", 32'(cycleCount), 32'd0);
      if (i == LD_MAX) checkOutput("capRunMemSel", 32'(memSel), 32'd0);
      checkOutput("capReady", 32'(ldReady), 32'(i < LD_MAX));
      checkOutput("capWrEn", 32'(memWrEn), 32'(i < LD_MAX));
      if (memWrEn) begin
        expWr = (wrQ.size() > 0) ? wrQ.pop_front() : 16'hxxxx;
        checkOutput("capWrite", 32'({memAddr, memWrData}), 32'(expWr));
      end
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("memByte3", 32'(mem[3]), 32'h43);

`ifdef CORE_RUN_TIMEOUT_EN
    // Watchdog: no done, DRAIN after MAX_CYC counted cycles
    n = 0;
    while (!rdValid && n < 40) begin
      nextCycle();
      n++;
    end
    @(negedge clk);
    checkOutput("wdDrain", 32'(rdValid), 32'd1);
    checkOutput("wdCount", 32'(cycleCount), 32'(MAX_CYC));
    checkOutput("wdTimeout", 32'(timeout), 32'd1);
    nextCycle();
    rdQ.push_back({1'b0, 8'hA5});
    rdQ.push_back({1'b1, 8'h5A});
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      expRd = (rdQ.size() > 0) ? rdQ.pop_front() : 9'hxxx;
      checkOutput("wdDrainByte", 32'({rdLast, rdData}), 32'(expRd));
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("wdIdleBusy", 32'(busy), 32'd0);
    checkOutput("wdSticky", 32'(timeout), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    wrQ.push_back({8'(LD_BASE), 8'h77});
    @(negedge clk);
    checkOutput("wdClearedByStart", 32'(timeout), 32'd0);
    expWr = (wrQ.size() > 0) ? wrQ.pop_front() : 16'hxxxx;
    checkOutput("reloadWrite", 32'({memAddr, memWrData}), 32'(expWr));
    nextCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) nextCycle();
`else
    // No watchdog: RUN keeps waiting and keeps counting
    n = 0;
    while (n < 20) begin
      nextCycle();
      n++;
    end
    @(negedge clk);
    checkOutput("noWdBusy", 32'(busy), 32'd1);
    checkOutput("noWdTimeout", 32'(timeout), 32'd0);
    checkOutput("noWdCount", 32'(cycleCount), 32'd21);
    nextCycle();
`endif

    // Async reset mid-RUN
    checkOutput("preRstMemSel", 32'(memSel), 32'd0);
    reset = 1'b0;
    #2;
    checkOutput("asyncBusy", 32'(busy), 32'd0);
    checkOutput("asyncCoreReset", 32'(coreReset), 32'd1);
    checkOutput("asyncMemSel", 32'(memSel), 32'd1);
    checkOutput("asyncCount", 32'(cycleCount), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("postRstBusy", 32'(busy), 32'd0);
    checkOutput("wrQueueEmpty", 32'(wrQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
